// File: rtl/rv_pkg.sv
// Shared helpers and reset constants for the rv stream stages.
package rv_pkg;

  localparam logic RV_RST_VAL = 1'b0;
  localparam logic RV_RST_RDY = 1'b1;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int lane_lo(input int i, input int w);
    return i * w;
  endfunction

endpackage

// File: rtl/rv_pack_if.sv
// Narrow-in / wide-out stream bundle for the rv packer.
interface rv_pack_if #(
  parameter int wd    = 4,
  parameter int ratio = 4
);

  logic [wd-1:0]       datain;
  logic                datain_val;
  logic                datain_last;
  logic                datain_rdy;
  logic [wd*ratio-1:0] dataout;
  logic [ratio-1:0]    dataout_keep;
  logic                dataout_last;
  logic                dataout_val;
  logic                dataout_rdy;

  modport master (
    output datain, datain_val, datain_last, dataout_rdy,
    input  datain_rdy, dataout, dataout_keep,
    input  dataout_last, dataout_val
  );

  modport slave (
    input  datain, datain_val, datain_last, dataout_rdy,
    output datain_rdy, dataout, dataout_keep,
    output dataout_last, dataout_val
  );

endinterface

// File: rtl/rv_pack.sv
// Packs ratio narrow beats into one wide word with lane keep;
// input ready is registered and never sees dataout_rdy combinationally.
module rv_pack
  import rv_pkg::*;
#(
  parameter int wd    = 4,
  parameter int ratio = 4
) (
  input logic     clk,
  input logic     rst_n,
  rv_pack_if.slave bus
);

  localparam int CW = cnt_w(ratio);
  localparam int OW = wd * ratio;

  logic [OW-1:0]    r_acc;
  logic [ratio-1:0] r_keep;
  logic [CW-1:0]    r_cnt;
  logic             r_last;
  logic             r_done;
  logic [OW-1:0]    r_out;
  logic [ratio-1:0] r_okeep;
  logic             r_olast;
  logic             r_oval;

  logic [OW-1:0]    w_macc;
  logic [ratio-1:0] w_mkeep;
  logic             w_rdy;
  logic             w_fire;
  logic             w_free;
  logic             w_cmpl;

  assign w_rdy  = ~r_done;
  assign w_fire = bus.datain_val & w_rdy;
  assign w_free = ~r_oval | bus.dataout_rdy;
  assign w_cmpl = (r_cnt == CW'(ratio - 1))
                | bus.datain_last;

  // accumulator with the incoming beat merged into lane r_cnt
  always_comb begin
    w_macc  = r_acc;
    w_mkeep = r_keep;
    for (int i = 0; i < ratio; i++) begin
      if (r_cnt == CW'(i)) begin
        w_macc[lane_lo(i, wd) +: wd] = bus.datain;
        w_mkeep[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_keep  <= '0;
      r_cnt   <= '0;
      r_last  <= RV_RST_VAL;
      r_done  <= ~RV_RST_RDY;
      r_out   <= '0;
      r_okeep <= '0;
      r_olast <= RV_RST_VAL;
      r_oval  <= RV_RST_VAL;
    end else begin
      if (bus.dataout_rdy) r_oval <= 1'b0;
      if (r_done) begin
        if (w_free) begin
          r_out   <= r_acc;
          r_okeep <= r_keep;
          r_olast <= r_last;
          r_oval  <= 1'b1;
          r_acc   <= '0;
          r_keep  <= '0;
          r_last  <= 1'b0;
          r_done  <= 1'b0;
        end
      end else if (w_fire) begin
        if (w_cmpl && w_free) begin
          r_out   <= w_macc;
          r_okeep <= w_mkeep;
          r_olast <= bus.datain_last;
          r_oval  <= 1'b1;
          r_acc   <= '0;
          r_keep  <= '0;
          r_cnt   <= '0;
        end else if (w_cmpl) begin
          // park the finished group; input stalls one cycle
          r_acc   <= w_macc;
          r_keep  <= w_mkeep;
          r_last  <= bus.datain_last;
          r_done  <= 1'b1;
          r_cnt   <= '0;
        end else begin
          r_acc   <= w_macc;
          r_keep  <= w_mkeep;
          r_cnt   <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.datain_rdy   = w_rdy;
  assign bus.dataout      = r_out;
  assign bus.dataout_keep = r_okeep;
  assign bus.dataout_last = r_olast;
  assign bus.dataout_val  = r_oval;

endmodule

// File: tb/tb_rv_pack.sv
// Directed and random checks of rv_pack against a packing
// scoreboard.
module tb_rv_pack;

  localparam int WD = 4;
  localparam int R  = 4;
  localparam int OW = WD * R;

  typedef struct packed {
    logic [OW-1:0] data;
    logic [R-1:0]  keep;
    logic          last;
  } word_t;

  logic clk;
  logic rst_n;

  rv_pack_if #(.wd(WD), .ratio(R)) bus ();

  rv_pack #(.wd(WD), .ratio(R)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert;
  int n_fail;

  word_t         q[$];
  logic [OW-1:0] m_word;
  logic [R-1:0]  m_keep;
  int            m_cnt;
  logic          stall;
  word_t         s_w;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // model: pack accepted beats, compare every output handshake
  always @(negedge clk) begin
    if (!rst_n) begin
      m_cnt  = 0;
      m_word = '0;
      m_keep = '0;
      stall  = 1'b0;
      q.delete();
    end else begin
      if (stall) begin
        chk("stall_val", 64'(bus.dataout_val), 64'd1);
        chk("stall_data", 64'(bus.dataout), 64'(s_w.data));
        chk("stall_keep", 64'(bus.dataout_keep),
            64'(s_w.keep));
        chk("stall_last", 64'(bus.dataout_last),
            64'(s_w.last));
      end
      if (bus.dataout_val && bus.dataout_rdy) begin
        if (q.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          word_t e;
          e = q.pop_front();
          chk("sb_data", 64'(bus.dataout), 64'(e.data));
          chk("sb_keep", 64'(bus.dataout_keep), 64'(e.keep));
          chk("sb_last", 64'(bus.dataout_last), 64'(e.last));
        end
      end
      stall = bus.dataout_val && !bus.dataout_rdy;
      s_w.data = bus.dataout;
      s_w.keep = bus.dataout_keep;
      s_w.last = bus.dataout_last;
      if (bus.datain_val && bus.datain_rdy) begin
        m_word[m_cnt*WD +: WD] = bus.datain;
        m_keep[m_cnt] = 1'b1;
        if (m_cnt == R - 1 || bus.datain_last) begin
          q.push_back('{data: m_word, keep: m_keep,
                        last: bus.datain_last});
          m_word = '0;
          m_keep = '0;
          m_cnt  = 0;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [WD-1:0] d,
                      input logic l);
    step();
    bus.datain_val  = 1'b1;
    bus.datain      = d;
    bus.datain_last = l;
  endtask

  task automatic idle();
    step();
    bus.datain_val  = 1'b0;
    bus.datain_last = 1'b0;
  endtask

  task automatic chk_out(input string tag,
                         input logic [OW-1:0] d,
                         input logic [R-1:0] k,
                         input logic l);
    chk({tag, "_val"}, 64'(bus.dataout_val), 64'd1);
    chk({tag, "_data"}, 64'(bus.dataout), 64'(d));
    chk({tag, "_keep"}, 64'(bus.dataout_keep), 64'(k));
    chk({tag, "_last"}, 64'(bus.dataout_last), 64'(l));
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_val"}, 64'(bus.dataout_val), 64'd0);
    chk({tag, "_data"}, 64'(bus.dataout), 64'd0);
    chk({tag, "_keep"}, 64'(bus.dataout_keep), 64'd0);
    chk({tag, "_last"}, 64'(bus.dataout_last), 64'd0);
    chk({tag, "_rdy"}, 64'(bus.datain_rdy), 64'd1);
  endtask

  logic took;

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n            = 1'b0;
    bus.datain       = '0;
    bus.datain_val   = 1'b0;
    bus.datain_last  = 1'b0;
    bus.dataout_rdy  = 1'b1;

    // 1: reset, then reset mid-group with a word held
    step();
    step();
    chk_rst("rst0");
    rst_n = 1'b1;
    bus.dataout_rdy = 1'b0;
    for (int k = 1; k <= 4; k++) beat(WD'(k), 1'b0);
    beat(4'h5, 1'b0);
    beat(4'h6, 1'b0);
    idle();
    @(negedge clk);
    chk_out("held", 16'h4321, 4'hF, 1'b0);
    step();
    rst_n = 1'b0;
    #1;
    chk_rst("rst_mid");
    step();
    rst_n = 1'b1;
    bus.dataout_rdy = 1'b1;

    // 2: streaming, full rate
    for (int k = 1; k <= 8; k++) begin
      beat(WD'(k), 1'b0);
      @(negedge clk);
      chk("stream_rdy", 64'(bus.datain_rdy), 64'd1);
      if (k == 5) chk_out("w0", 16'h4321, 4'hF, 1'b0);
    end
    idle();
    @(negedge clk);
    chk_out("w1", 16'h8765, 4'hF, 1'b0);

    // 3: early last, then last on the first beat
    beat(4'hA, 1'b0);
    beat(4'hB, 1'b1);
    idle();
    @(negedge clk);
    chk_out("early", 16'h00BA, 4'h3, 1'b1);
    beat(4'hC, 1'b1);
    idle();
    @(negedge clk);
    chk_out("first", 16'h000C, 4'h1, 1'b1);
    idle();
    idle();

    // 4: backpressure
    bus.dataout_rdy = 1'b0;
    for (int k = 1; k <= 8; k++) beat(WD'(k), 1'b0);
    beat(4'h9, 1'b0);
    @(negedge clk);
    chk("bp_rdy0", 64'(bus.datain_rdy), 64'd0);
    chk_out("bp_hold0", 16'h4321, 4'hF, 1'b0);
    for (int k = 0; k < 2; k++) begin
      step();
      @(negedge clk);
      chk("bp_rdy_hold", 64'(bus.datain_rdy), 64'd0);
      chk_out("bp_hold", 16'h4321, 4'hF, 1'b0);
    end
    step();
    bus.dataout_rdy = 1'b1;
    @(negedge clk);
    chk("bp_rdy_pre", 64'(bus.datain_rdy), 64'd0);
    step();
    @(negedge clk);
    chk_out("bp_w1", 16'h8765, 4'hF, 1'b0);
    chk("bp_rdy_back", 64'(bus.datain_rdy), 64'd1);
    beat(4'hA, 1'b0);
    beat(4'hB, 1'b0);
    beat(4'hC, 1'b0);
    idle();
    @(negedge clk);
    chk_out("bp_w2", 16'hCBA9, 4'hF, 1'b0);
    idle();
    idle();

    // 5: drain and reload on the same edge
    bus.dataout_rdy = 1'b0;
    for (int k = 1; k <= 7; k++) beat(WD'(k), 1'b0);
    step();
    bus.datain       = 4'h8;
    bus.dataout_rdy  = 1'b1;
    @(negedge clk);
    chk_out("sim_old", 16'h4321, 4'hF, 1'b0);
    chk("sim_rdy", 64'(bus.datain_rdy), 64'd1);
    idle();
    @(negedge clk);
    chk_out("sim_new", 16'h8765, 4'hF, 1'b0);
    idle();
    idle();

    // 6: random traffic against the scoreboard
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      took = bus.datain_val && bus.datain_rdy;
      step();
      if (!bus.datain_val || took) begin
        bus.datain_val  = ($urandom_range(0, 3) != 0);
        bus.datain      = WD'($urandom);
        bus.datain_last = ($urandom_range(0, 4) == 0);
      end
      bus.dataout_rdy = ($urandom_range(0, 2) != 0);
    end
    @(negedge clk);
    took = bus.datain_val && bus.datain_rdy;
    step();
    if (took) bus.datain_val = 1'b0;
    bus.dataout_rdy = 1'b1;
    // finish any partial group so nothing is left in the packer
    while (bus.datain_val) begin
      @(negedge clk);
      took = bus.datain_val && bus.datain_rdy;
      step();
      if (took) bus.datain_val = 1'b0;
    end
    bus.datain_val  = 1'b1;
    bus.datain_last = 1'b1;
    bus.datain      = 4'hE;
    @(negedge clk);
    took = bus.datain_val && bus.datain_rdy;
    for (int k = 0; k < 4 && !took; k++) begin
      step();
      @(negedge clk);
      took = bus.datain_val && bus.datain_rdy;
    end
    chk("flush_taken", 64'(took), 64'd1);
    idle();
    for (int k = 0; k < 8; k++) idle();
    @(negedge clk);
    chk("sb_empty", 64'(q.size()), 64'd0);
    chk("end_val", 64'(bus.dataout_val), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
